// File: rtl/switch_loader32_if.sv
// Byte-wide switch loader bus: switch byte, lane select, raw button, clear,
// and the assembled 32-bit register with its status flags.
interface switch_loader32_if;
    logic [7:0]  din;
    logic [1:0]  sel;
    logic        load_btn;
    logic        clr;
    logic [31:0] value;
    logic [3:0]  lanes_written;
    logic        full;
    logic        write_strobe;

    modport master (
        output din, sel, load_btn, clr,
        input  value, lanes_written, full, write_strobe
    );

    modport slave (
        input  din, sel, load_btn, clr,
        output value, lanes_written, full, write_strobe
    );
endinterface

// File: rtl/switch_loader32.sv
// Loads a 32-bit register one byte lane at a time from slide switches,
// committing on each debounced push-button press.
//
// state   | meaning
// IDLE    | button released and stable, waiting for a press
// PRESS   | button seen high, counting consecutive high samples
// HELD    | press accepted (one commit issued), waiting for release
// RELEASE | button seen low, counting consecutive low samples
module switch_loader32 #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    switch_loader32_if.slave  bus
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {IDLE, PRESS, HELD, RELEASE} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          commit;
    logic          b_m, b_s;
    logic [31:0]   value;
    logic [3:0]    lanes_written;
    logic          write_strobe;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            b_m <= 1'b0;
            b_s <= 1'b0;
        end else begin
            b_m <= bus.load_btn;
            b_s <= b_m;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        commit    = 1'b0;
        case (state)
            IDLE: begin
                if (b_s) begin
                    state_nxt = PRESS;
                    cnt_nxt   = CNT_ONE;
                end
            end
            PRESS: begin
                if (!b_s) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = HELD;
                    cnt_nxt   = '0;
                    commit    = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            HELD: begin
                if (!b_s) begin
                    state_nxt = RELEASE;
                    cnt_nxt   = CNT_ONE;
                end
            end
            RELEASE: begin
                if (b_s) begin
                    state_nxt = HELD;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // clr overrides a coincident commit; the FSM still consumes the press.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value         <= '0;
            lanes_written <= '0;
            write_strobe  <= 1'b0;
        end else if (bus.clr) begin
            value         <= '0;
            lanes_written <= '0;
            write_strobe  <= 1'b0;
        end else begin
            write_strobe <= commit;
            if (commit) begin
                value[{bus.sel, 3'b000} +: 8] <= bus.din;
                lanes_written[bus.sel]        <= 1'b1;
            end
        end
    end

    assign bus.value         = value;
    assign bus.lanes_written = lanes_written;
    assign bus.full          = &lanes_written;
    assign bus.write_strobe  = write_strobe;
endmodule

// File: tb/tb_switch_loader32.sv
// Directed bench for switch_loader32 with a run-length debounce model
// compared against the DUT on every falling edge.
module tb_switch_loader32;
    localparam int D = 4;

    logic clk;
    logic rst;
    switch_loader32_if bus ();

    switch_loader32 #(.DEBOUNCE_CYCLES(D)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Model: the debounced level flips after D consecutive synchronized samples
    // that disagree with it; a flip to 1 is a commit.
    logic        m_s1, m_s2, m_level, m_commit;
    int          m_run;
    logic [31:0] m_value;
    logic [3:0]  m_lanes;
    logic        m_strobe;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_s1 = 0; m_s2 = 0; m_level = 0; m_run = 0;
            m_value = 0; m_lanes = 0; m_strobe = 0;
        end else begin
            m_commit = 0;
            if (m_s2 != m_level) begin
                m_run++;
                if (m_run == D) begin
                    m_level  = ~m_level;
                    m_run    = 0;
                    m_commit = m_level;
                end
            end else begin
                m_run = 0;
            end
            m_s2 = m_s1;
            m_s1 = bus.load_btn;
            if (bus.clr) begin
                m_value = 0; m_lanes = 0; m_strobe = 0;
            end else begin
                m_strobe = m_commit;
                if (m_commit) begin
                    m_value[8*bus.sel +: 8] = bus.din;
                    m_lanes[bus.sel]        = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("model_value", bus.value, m_value);
        chk("model_lanes", {28'd0, bus.lanes_written}, {28'd0, m_lanes});
        chk("model_full", {31'd0, bus.full}, {31'd0, &m_lanes});
        chk("model_strobe", {31'd0, bus.write_strobe}, {31'd0, m_strobe});
    end

    // Called right after a falling edge; index i names the rising edge just passed.
    task automatic press(input logic [1:0] s, input logic [7:0] d, input int hold,
                         output int n, output int at);
        bus.sel = s; bus.din = d; bus.load_btn = 1'b1;
        n = 0; at = -1;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (bus.write_strobe) begin n++; at = i; end
        end
    endtask

    task automatic release_btn(output int n);
        bus.load_btn = 1'b0;
        n = 0;
        for (int i = 0; i < 2*D + 2; i++) begin
            @(negedge clk);
            if (bus.write_strobe) n++;
        end
    endtask

    int n, at, nr;
    logic [7:0] fill_din [4];
    logic [0:0] pattern [12];

    initial begin
        fill_din[0] = 8'h11; fill_din[1] = 8'h22; fill_din[2] = 8'h33; fill_din[3] = 8'h44;
        rst = 1'b1;
        bus.din = 0; bus.sel = 0; bus.load_btn = 0; bus.clr = 0;
        repeat (2) @(negedge clk);
        chk("reset_value", bus.value, 32'h0);
        chk("reset_lanes", {28'd0, bus.lanes_written}, 32'h0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // clean press
        press(2'b10, 8'hA5, 12, n, at);
        chk("clean_strobe_count", n, 1);
        chk("clean_strobe_edge", at, 5);
        chk("clean_value", bus.value, 32'h00A5_0000);
        chk("clean_lanes", {28'd0, bus.lanes_written}, 32'h4);
        release_btn(nr);
        chk("clean_release_strobes", nr, 0);

        // bounce: H H L H H L then held; final rise before edge 6
        pattern = '{1'b1,1'b1,1'b0,1'b1,1'b1,1'b0,1'b1,1'b1,1'b1,1'b1,1'b1,1'b1};
        bus.sel = 2'b01; bus.din = 8'h3C;
        n = 0; at = -1;
        for (int i = 0; i < 16; i++) begin
            bus.load_btn = (i < 12) ? pattern[i][0] : 1'b1;
            @(negedge clk);
            if (bus.write_strobe) begin n++; at = i; end
        end
        chk("bounce_strobe_count", n, 1);
        chk("bounce_strobe_edge", at, 11);
        chk("bounce_value", bus.value, 32'h00A5_3C00);
        // release bounce: L L H then low held
        n = 0;
        for (int i = 0; i < 12; i++) begin
            bus.load_btn = (i == 2) ? 1'b1 : 1'b0;
            @(negedge clk);
            if (bus.write_strobe) n++;
        end
        chk("release_bounce_strobes", n, 0);

        // fill all lanes
        bus.clr = 1'b1; @(negedge clk); bus.clr = 1'b0;
        chk("clr_value", bus.value, 32'h0);
        for (int k = 0; k < 4; k++) begin
            press(2'(k), fill_din[k], 8, n, at);
            chk("fill_strobe", n, 1);
            chk("fill_full", {31'd0, bus.full}, {31'd0, k == 3});
            release_btn(nr);
        end
        chk("fill_value", bus.value, 32'h4433_2211);
        press(2'b00, 8'hFF, 8, n, at);
        release_btn(nr);
        chk("overwrite_value", bus.value, 32'h4433_22FF);
        chk("overwrite_full", {31'd0, bus.full}, 32'h1);

        // clear collision on commit edge 5
        bus.clr = 1'b1; @(negedge clk); bus.clr = 1'b0;
        press(2'b00, 8'h11, 8, n, at);
        release_btn(nr);
        chk("partial_lanes", {28'd0, bus.lanes_written}, 32'h1);
        bus.sel = 2'b01; bus.din = 8'h77; bus.load_btn = 1'b1;
        n = 0;
        for (int i = 0; i < 8; i++) begin
            bus.clr = (i == 5) ? 1'b1 : 1'b0;
            @(negedge clk);
            if (bus.write_strobe) n++;
        end
        bus.clr = 1'b0;
        chk("collide_strobes", n, 0);
        chk("collide_value", bus.value, 32'h0);
        chk("collide_lanes", {28'd0, bus.lanes_written}, 32'h0);
        release_btn(nr);
        press(2'b10, 8'h99, 8, n, at);
        chk("after_collide_edge", at, 5);
        chk("after_collide_value", bus.value, 32'h0099_0000);
        release_btn(nr);

        // reset mid-debounce (PRESS, cnt=2 after edge 3)
        bus.sel = 2'b11; bus.din = 8'h5A; bus.load_btn = 1'b1;
        repeat (4) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("midrst_value", bus.value, 32'h0);
        chk("midrst_lanes", {28'd0, bus.lanes_written}, 32'h0);
        chk("midrst_full", {31'd0, bus.full}, 32'h0);
        chk("midrst_strobe", {31'd0, bus.write_strobe}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        press(2'b11, 8'h5A, 10, n, at);
        chk("midrst_commit_count", n, 1);
        chk("midrst_commit_edge", at, 5);
        chk("midrst_commit_value", bus.value, 32'h5A00_0000);
        release_btn(nr);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
